// File: rtl/cubestate_uart_tx.sv
// cubestate_uart_tx
// Serialises a 54-sticker cube state over a UART line as one 56-byte frame:
// HEADER, 54 sticker bytes {5'b0, colour}, then an 8-bit sum of the sticker bytes.
// Line format is 8N1, LSB first, idle high, with a one-cycle gap between bytes.
//
// Ports
//   clock      system clock (25 MHz domain)
//   reset      synchronous, active-high
//   send_data  transmit request, a rising edge starts one frame
//   data       162-bit cube state, sticker k = data[161-3k -: 3]
//   tx_pin     UART transmit line
//   data_sent  1 = idle / frame complete, 0 = frame in progress
//   state      FSM state code for debug display
module cubestate_uart_tx #(
  parameter int         CLKS_PER_BIT = 217,
  parameter logic [7:0] HEADER       = 8'hA5
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         send_data,
  input  logic [161:0] data,
  output logic         tx_pin,
  output logic         data_sent,
  output logic [2:0]   state
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    START = 3'd1,
    DATA  = 3'd2,
    STOP  = 3'd3,
    NEXT  = 3'd4
  } state_e;

  localparam int CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [5:0] LAST_BYTE    = 6'd55;
  localparam logic [5:0] LAST_STICKER = 6'd54;

  state_e         state_q, state_d;
  logic [CNT_W-1:0] clk_cnt_q, clk_cnt_d;
  logic [2:0]     bit_idx_q, bit_idx_d;
  logic [5:0]     byte_idx_q, byte_idx_d;
  logic [7:0]     tx_byte_q, tx_byte_d;
  logic [7:0]     checksum_q, checksum_d;
  logic [161:0]   shadow_q, shadow_d;
  logic           send_prev_q, send_prev_d;

  logic           start_req;
  logic           bit_done;
  logic [7:0]     sticker_byte;

  // The shadow register shifts left as stickers are consumed, so the next
  // sticker to send is always in its top three bits.
  assign start_req    = send_data & ~send_prev_q;
  assign bit_done     = (clk_cnt_q == CNT_LAST);
  assign sticker_byte = {5'b0, shadow_q[161:159]};

  // State register; reset holds the request copy high so a request that is
  // already high when reset releases does not count as a new edge.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q     <= IDLE;
      clk_cnt_q   <= '0;
      bit_idx_q   <= '0;
      byte_idx_q  <= '0;
      tx_byte_q   <= '0;
      checksum_q  <= '0;
      shadow_q    <= '0;
      send_prev_q <= 1'b1;
    end else begin
      state_q     <= state_d;
      clk_cnt_q   <= clk_cnt_d;
      bit_idx_q   <= bit_idx_d;
      byte_idx_q  <= byte_idx_d;
      tx_byte_q   <= tx_byte_d;
      checksum_q  <= checksum_d;
      shadow_q    <= shadow_d;
      send_prev_q <= send_prev_d;
    end
  end

  // Next-state logic. The checksum is accumulated as each sticker byte is
  // loaded in NEXT, so it is complete by the time byte 55 is loaded.
  always_comb begin
    state_d     = state_q;
    clk_cnt_d   = clk_cnt_q;
    bit_idx_d   = bit_idx_q;
    byte_idx_d  = byte_idx_q;
    tx_byte_d   = tx_byte_q;
    checksum_d  = checksum_q;
    shadow_d    = shadow_q;
    send_prev_d = send_data;

    unique case (state_q)
      IDLE: begin
        if (start_req) begin
          shadow_d   = data;
          byte_idx_d = '0;
          tx_byte_d  = HEADER;
          checksum_d = '0;
          clk_cnt_d  = '0;
          bit_idx_d  = '0;
          state_d    = START;
        end
      end
      START: begin
        if (bit_done) begin
          clk_cnt_d = '0;
          bit_idx_d = '0;
          state_d   = DATA;
        end else begin
          clk_cnt_d = clk_cnt_q + 1'b1;
        end
      end
      DATA: begin
        if (bit_done) begin
          clk_cnt_d = '0;
          if (bit_idx_q == 3'd7) begin
            bit_idx_d = '0;
            state_d   = STOP;
          end else begin
            bit_idx_d = bit_idx_q + 1'b1;
          end
        end else begin
          clk_cnt_d = clk_cnt_q + 1'b1;
        end
      end
      STOP: begin
        if (bit_done) begin
          clk_cnt_d = '0;
          state_d   = (byte_idx_q == LAST_BYTE) ? IDLE : NEXT;
        end else begin
          clk_cnt_d = clk_cnt_q + 1'b1;
        end
      end
      NEXT: begin
        byte_idx_d = byte_idx_q + 1'b1;
        if (byte_idx_q == LAST_STICKER) begin
          tx_byte_d = checksum_q;
        end else begin
          tx_byte_d  = sticker_byte;
          checksum_d = checksum_q + sticker_byte;
          shadow_d   = {shadow_q[158:0], 3'b000};
        end
        state_d = START;
      end
      default: state_d = IDLE;
    endcase
  end

  // Line driver: low for the start bit, data bits LSB first, high otherwise
  // (stop bit, inter-byte gap and idle).
  always_comb begin
    tx_pin = 1'b1;
    unique case (state_q)
      START:   tx_pin = 1'b0;
      DATA:    tx_pin = tx_byte_q[bit_idx_q];
      default: tx_pin = 1'b1;
    endcase
  end

  assign data_sent = (state_q == IDLE);
  assign state     = state_q;

endmodule

// File: tb/tb_cubestate_uart_tx.sv
// Testbench for cubestate_uart_tx (CLKS_PER_BIT = 4).
// Stimulus pushes the expected frame bytes into a queue; an independent UART
// receiver on tx_pin decodes bytes, checks bit timing and gaps, and pops and
// compares against the queue.
module tb_cubestate_uart_tx;

  localparam int CPB          = 4;
  localparam int FRAME_CYCLES = 56 * (10 * CPB + 1) - 1;

  logic         clock = 1'b0;
  logic         reset = 1'b1;
  logic         send_data = 1'b0;
  logic [161:0] data = '0;
  logic         tx_pin;
  logic         data_sent;
  logic [2:0]   state;

  int checks = 0;
  int errors = 0;
  logic [7:0] exp_q[$];
  int frames_seen = 0;

  cubestate_uart_tx #(.CLKS_PER_BIT(CPB), .HEADER(8'hA5)) dut (
    .clock     (clock),
    .reset     (reset),
    .send_data (send_data),
    .data      (data),
    .tx_pin    (tx_pin),
    .data_sent (data_sent),
    .state     (state)
  );

  always #5 clock = ~clock;

  // One comparison; X/Z on the actual value counts as a failure.
  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
    end
  endtask

  // Reference model: header, each sticker zero-extended to a byte, then the
  // byte sum of the stickers modulo 256.
  task automatic pushFrame(input logic [161:0] d);
    int sum;
    logic [2:0] s;
    sum = 0;
    exp_q.push_back(8'hA5);
    for (int k = 0; k < 54; k++) begin
      s = d[161 - 3*k -: 3];
      exp_q.push_back({5'b0, s});
      sum = sum + int'(s);
    end
    exp_q.push_back(8'(sum % 256));
  endtask

  task automatic waitLevel(input logic level, input int budget, input string name);
    int n;
    n = 0;
    while (data_sent !== level && n < budget) begin
      @(negedge clock);
      n++;
    end
    checkOutput(name, {31'd0, data_sent}, {31'd0, level});
  endtask

  task automatic pulseSend();
    @(posedge clock); #1 send_data = 1'b1;
    @(posedge clock); #1 send_data = 1'b0;
  endtask

  // Issue one single-cycle request for data d and wait for the frame to end.
  task automatic applyStimulus(input logic [161:0] d);
    int f0;
    f0 = frames_seen;
    data = d;
    pushFrame(d);
    pulseSend();
    waitLevel(1'b0, 20, "frameStart");
    waitLevel(1'b1, FRAME_CYCLES + 50, "frameEnd");
    repeat (5) @(negedge clock);
    checkOutput("framesPerRequest", frames_seen - f0, 1);
  endtask

  task automatic handshake(input logic [161:0] d);
    int f0;
    f0 = frames_seen;
    data = d;
    pushFrame(d);
    @(posedge clock); #1 send_data = 1'b1;
    waitLevel(1'b0, 20, "hsBusy");
    @(posedge clock); #1 send_data = 1'b0;
    waitLevel(1'b1, FRAME_CYCLES + 50, "hsDone");
    repeat (5) @(negedge clock);
    checkOutput("hsFrames", frames_seen - f0, 1);
  endtask

  function automatic logic [161:0] randomCube();
    logic [161:0] d;
    d = '0;
    for (int k = 0; k < 54; k++) d[161 - 3*k -: 3] = 3'($urandom_range(0, 7));
    return d;
  endfunction

  // Receiver / monitor: decodes tx_pin every falling clock edge, checks each
  // bit lasts CPB samples, the one-cycle gap inside a frame, the state codes,
  // and the data_sent low time of each complete frame.
  int         cyc = 0;
  int         rx_pos = -1;
  logic [7:0] rx_byte = '0;
  bit         timing_ok, state_ok;
  int         last_stop_cyc = 0;
  int         byte_in_frame = 0;
  int         ds_low = 0;
  bit         ds_aborted = 1'b0;
  logic       prev_ds = 1'bx;

  always @(negedge clock) begin
    int slot, sub;
    cyc++;
    if (reset) begin
      rx_pos        = -1;
      byte_in_frame = 0;
      ds_low        = 0;
      ds_aborted    = 1'b1;
    end else begin
      if (rx_pos < 0 && tx_pin === 1'b0) begin
        if (byte_in_frame != 0) checkOutput("byteGap", cyc - last_stop_cyc, 2);
        rx_pos    = 0;
        timing_ok = 1'b1;
        state_ok  = (state === 3'd1);
      end
      if (rx_pos >= 0) begin
        slot = rx_pos / CPB;
        sub  = rx_pos % CPB;
        if (slot == 0) begin
          if (tx_pin !== 1'b0) timing_ok = 1'b0;
        end else if (slot <= 8) begin
          if (tx_pin !== 1'b0 && tx_pin !== 1'b1) timing_ok = 1'b0;
          if (sub == 0) rx_byte[slot-1] = tx_pin;
          else if (tx_pin !== rx_byte[slot-1]) timing_ok = 1'b0;
        end else begin
          if (tx_pin !== 1'b1) timing_ok = 1'b0;
        end
        if (rx_pos == CPB && state !== 3'd2) state_ok = 1'b0;
        if (rx_pos == 9*CPB && state !== 3'd3) state_ok = 1'b0;
        if (rx_pos == 10*CPB - 1) begin
          checkOutput("bitTiming", {31'd0, timing_ok}, 32'd1);
          checkOutput("stateCode", {31'd0, state_ok}, 32'd1);
          if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("[TB] FAIL unexpectedByte: got %0h, expected no byte", rx_byte);
          end else begin
            checkOutput($sformatf("byte%0d", byte_in_frame), {24'd0, rx_byte}, {24'd0, exp_q.pop_front()});
          end
          last_stop_cyc = cyc;
          byte_in_frame = (byte_in_frame + 1) % 56;
          rx_pos = -1;
        end else begin
          rx_pos++;
        end
      end

      if (data_sent === 1'b0) begin
        if (prev_ds === 1'b1) frames_seen++;
        ds_low++;
      end else if (data_sent === 1'b1) begin
        if (prev_ds === 1'b0 && !ds_aborted) checkOutput("frameLength", ds_low, FRAME_CYCLES);
        ds_low     = 0;
        ds_aborted = 1'b0;
      end
    end
    prev_ds = data_sent;
  end

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation still running, expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic [161:0] d;
    int f0, lows;

    // Reset state
    repeat (3) @(posedge clock);
    @(negedge clock);
    checkOutput("resetTx", {31'd0, tx_pin}, 32'd1);
    checkOutput("resetDataSent", {31'd0, data_sent}, 32'd1);
    checkOutput("resetState", {29'd0, state}, 32'd0);
    @(posedge clock); #1 reset = 1'b0;
    repeat (3) @(posedge clock);

    // Solved cube: colours 5,4,3,2,1,0 in blocks of nine
    d = '0;
    for (int k = 0; k < 54; k++) d[161 - 3*k -: 3] = 3'(5 - k / 9);
    applyStimulus(d);

    // Every sticker colour 5: checksum wraps
    d = '0;
    for (int k = 0; k < 54; k++) d[161 - 3*k -: 3] = 3'd5;
    applyStimulus(d);

    // All zero
    applyStimulus('0);

    // Random cubes
    for (int i = 0; i < 3; i++) applyStimulus(randomCube());

    // Top-level handshake, twice
    handshake(randomCube());
    handshake(randomCube());

    // Request held high for three frame lengths
    d = randomCube();
    data = d;
    pushFrame(d);
    f0 = frames_seen;
    @(posedge clock); #1 send_data = 1'b1;
    repeat (3 * FRAME_CYCLES) @(posedge clock);
    #1 send_data = 1'b0;
    repeat (10) @(negedge clock);
    checkOutput("heldFrames", frames_seen - f0, 1);
    checkOutput("heldIdle", {31'd0, data_sent}, 32'd1);

    // Extra pulses while busy
    d = randomCube();
    data = d;
    pushFrame(d);
    f0 = frames_seen;
    pulseSend();
    repeat (300) @(posedge clock);
    for (int i = 0; i < 3; i++) begin
      pulseSend();
      repeat (50) @(posedge clock);
    end
    waitLevel(1'b1, FRAME_CYCLES + 50, "pulsesDone");
    repeat (10) @(negedge clock);
    checkOutput("pulsesFrames", frames_seen - f0, 1);

    // Data changes mid-frame
    d = randomCube();
    data = d;
    pushFrame(d);
    pulseSend();
    repeat (200) @(posedge clock);
    #1 data = ~d;
    repeat (700) @(posedge clock);
    #1 data = randomCube();
    waitLevel(1'b1, FRAME_CYCLES + 50, "changeDone");
    repeat (5) @(negedge clock);

    // Reset in byte 10, data bit 3, with the request held high throughout
    d = randomCube();
    data = d;
    pushFrame(d);
    f0 = frames_seen;
    @(posedge clock); #1 send_data = 1'b1;
    @(posedge clock);
    repeat (427) @(posedge clock);
    #1 reset = 1'b1;
    exp_q.delete();
    @(posedge clock);
    @(negedge clock);
    checkOutput("abortTx", {31'd0, tx_pin}, 32'd1);
    checkOutput("abortDataSent", {31'd0, data_sent}, 32'd1);
    checkOutput("abortState", {29'd0, state}, 32'd0);
    @(posedge clock); #1 reset = 1'b0;
    lows = 0;
    repeat (500) begin
      @(negedge clock);
      if (tx_pin !== 1'b1 || data_sent !== 1'b1) lows++;
    end
    checkOutput("heldAfterReset", lows, 0);
    checkOutput("abortFrames", frames_seen - f0, 1);
    @(posedge clock); #1 send_data = 1'b0;
    d = randomCube();
    data = d;
    pushFrame(d);
    @(posedge clock); #1 send_data = 1'b1;
    waitLevel(1'b0, 20, "retoggleStart");
    waitLevel(1'b1, FRAME_CYCLES + 50, "retoggleEnd");
    #1 send_data = 1'b0;
    repeat (10) @(negedge clock);
    checkOutput("retoggleFrames", frames_seen - f0, 2);

    checkOutput("queueEmpty", exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/cubestate_uart_tx.md
CUBESTATE_UART_TX -- requirements
Module: cubestate_uart_tx

Interface
REQ-001 The block SHALL have one clock and one reset: reset is synchronous and active-high.
REQ-002 Parameter CLKS_PER_BIT, default 217, SHALL set the clock_25mhz cycles per UART bit (115200 baud at 25 MHz).
REQ-003 Parameter HEADER, default 8'hA5, SHALL set the frame start byte.
REQ-004 clock  input  1  system clock, clock_25mhz domain.
REQ-005 reset  input  1  synchronous, active-high.
REQ-006 send_data  input  1  transmit request; a rising edge starts one frame.
REQ-007 data  input  162  cubestate, 54 stickers x 3-bit color code; sticker k = data[161-3k -: 3], k=0..53.
REQ-008 tx_pin  output  1  UART TX line: 8N1, LSB first, idle high.
REQ-009 data_sent  output  1  high = idle or frame complete; low = frame in progress.
REQ-010 state  output  3  FSM state code, for debug display.

Function
REQ-011 Frame SHALL be 56 bytes in order: HEADER, then 54 sticker bytes {5'b0, sticker k} for k=0..53, then CHECKSUM.
REQ-012 CHECKSUM SHALL be the sum of the 54 sticker bytes, truncated to 8 bits (wraps mod 256; the header is excluded).
REQ-013 FSM states and codes: IDLE=0, START=1, DATA=2, STOP=3, NEXT=4.
REQ-014 Edge detection: a registered copy of send_data SHALL be kept; a start is a sample with send_data=1 and the previous sample=0.
REQ-015 In IDLE, a detected start SHALL do the following at that edge: latch data into a 162-bit shadow register, clear the byte index, load HEADER, enter START.
REQ-016 From the cycle after the start edge, data_sent SHALL be 0 and tx_pin SHALL be 0.
REQ-017 START, DATA (8 bits, LSB first) and STOP (tx_pin=1) SHALL each hold every bit for exactly CLKS_PER_BIT cycles, timed by a bit-period counter.
REQ-018 At the end of STOP, NEXT SHALL run for one cycle: increment the byte index, load the next byte, return to START.
REQ-019 After byte 55 (CHECKSUM) the FSM SHALL go to IDLE instead of NEXT.
REQ-020 The byte gap SHALL be exactly one cycle (the NEXT cycle).
REQ-021 data_sent SHALL return to 1 in the first cycle after the final stop bit completes.
REQ-022 Total frame length SHALL be 56*(10*CLKS_PER_BIT+1)-1 cycles from the start edge to data_sent=1.
REQ-023 Changes on data after the start edge SHALL NOT affect the frame in progress.
REQ-024 Rising edges on send_data while busy SHALL be ignored, not queued.
REQ-025 If send_data is still high at frame end, no new frame SHALL start until send_data goes low and then high again.
REQ-026 The checksum accumulator SHALL be cleared at start and updated as each sticker byte is loaded.
REQ-027 CHECKSUM SHALL be final before byte 55 is loaded.

Reset
REQ-028 On reset, from the next cycle: tx_pin=1, data_sent=1, state=IDLE, bit and byte counters=0, checksum=0.
REQ-029 On reset, the registered send_data copy SHALL be set to 1, so a request held high through reset does not trigger.
REQ-030 Reset mid-frame SHALL abort the frame immediately with no further bits driven; the line stays high.
REQ-031 Reset SHALL take priority over a simultaneous send_data edge.

Verification (CLKS_PER_BIT=4)
REQ-032 Solved cube (stickers 5x9,4x9,3x9,2x9,1x9,0x9), send_data pulsed -> bytes A5, 05 (x9), 04 (x9), 03 (x9), 02 (x9), 01 (x9), 00 (x9), checksum 87; data_sent low for exactly 2295 cycles.
REQ-033 data all-ones-code (every sticker 3'd5) -> 54 bytes of 05; checksum 0E (270 mod 256 wraps).
REQ-034 data all zero -> A5, 54 x 00, 00; bit timing checked: each bit 4 cycles, one-cycle gap between bytes.
REQ-035 Handshake as driven by the top level: raise send_data, wait for data_sent=0, drop send_data, wait for data_sent=1 -> exactly one frame.
REQ-036 Second handshake (REQ-035 sequence repeated) -> exactly one more frame.
REQ-037 Holding send_data high for 3 frame lengths -> exactly one frame.
REQ-038 Extra send_data pulses mid-frame -> no additional frames.
REQ-039 data changed mid-frame -> transmitted bytes unchanged.
REQ-040 Reset asserted in byte 10, bit 3 -> tx_pin=1 and data_sent=1 next cycle, state=0.
REQ-041 After the mid-frame reset, send_data held high -> no frame until it toggles low then high.
